// File: rtl/cqu_mips_pkg.sv
// Shared types and constants for the cqu_mips fetch path.
// Holds the prefetch-buffer entry layout used by the fetch stage and its FIFO.
package cqu_mips_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0] NOP_INST   = '0;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
    logic              misalign;
  } if_entry_t;

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-stage bus bundle: redirect input, imem req/gnt/rvalid port and the valid/ready link to ID.
// master = fetch stage, slave = environment (imem, ID, redirect source).
interface if_prefetch_if;
  import cqu_mips_pkg::*;

  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [INST_W-1:0] out_inst;
  logic              out_misalign;

  modport master (
    input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_pc, out_inst, out_misalign
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_pc, out_inst, out_misalign
  );

endinterface

// File: rtl/if_fifo.sv
// Prefetch buffer: DEPTH-entry synchronous FIFO of if_entry_t; head is registered data, no bypass.
// Push when full / pop when empty are ignored; flush empties the FIFO and overrides push and pop.
module if_fifo
  import cqu_mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  if_entry_t                  push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output if_entry_t                  head
);

  localparam int PTR_W = $clog2(DEPTH);

  if_entry_t        mem_q [DEPTH];
  if_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != (PTR_W+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch stage: credit-limited imem requests into a prefetch FIFO; one-cycle response-to-output.
// ID backpressure via out_ready; redirect flushes and marks in-flight reads stale. IF_ALIGN_CHECK_EN adds misaligned-target trap entry.
module if_prefetch
  import cqu_mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUT    = 2
) (
  input  logic           clk,
  input  logic           rstn,
  if_prefetch_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   live;
  logic             req, grant, push, pop, flush;
  if_entry_t        push_entry, head;
  logic [31:0]      redir_pc;

`ifdef IF_ALIGN_CHECK_EN
  logic halt_q, halt_d, mis_pend_q, mis_pend_d;
  logic redir_misaligned;
  assign redir_pc         = bus.redirect_pc;
  assign redir_misaligned = |bus.redirect_pc[1:0];
`else
  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;
`endif

  // Slots already promised: buffered entries plus live (non-stale) reads in flight.
  assign live = {1'b0, fifo_count} + {1'b0, outstanding_q} - {1'b0, discard_q};

  always_comb begin
    req = rstn && !bus.redirect_valid
        && (outstanding_q < CNT_W'(MAX_OUT))
        && (live < (CNT_W+1)'(FIFO_DEPTH));
`ifdef IF_ALIGN_CHECK_EN
    req = req && !halt_q;
`endif
  end

  assign grant = req && bus.imem_gnt;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    push_entry    = '0;
    flush         = 1'b0;
    pop           = bus.out_ready && (fifo_count != '0);
`ifdef IF_ALIGN_CHECK_EN
    halt_d        = halt_q;
    mis_pend_d    = mis_pend_q;
`endif
    if (bus.redirect_valid) begin
      // req is held low here, so every read still in flight after this edge is stale.
      flush         = 1'b1;
      pop           = 1'b0;
      fetch_pc_d    = redir_pc;
      resp_pc_d     = redir_pc;
      outstanding_d = outstanding_q - CNT_W'(bus.imem_rvalid);
      discard_d     = outstanding_q - CNT_W'(bus.imem_rvalid);
`ifdef IF_ALIGN_CHECK_EN
      halt_d        = redir_misaligned;
      mis_pend_d    = redir_misaligned;
`endif
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(bus.imem_rvalid);
      if (bus.imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          push            = 1'b1;
          push_entry.pc   = resp_pc_q;
          push_entry.inst = bus.imem_rdata;
          resp_pc_d       = resp_pc_q + 32'd4;
        end
      end
`ifdef IF_ALIGN_CHECK_EN
      if (mis_pend_q && !push && (live < (CNT_W+1)'(FIFO_DEPTH))) begin
        push                = 1'b1;
        push_entry.pc       = resp_pc_q;
        push_entry.inst     = NOP_INST;
        push_entry.misalign = 1'b1;
        mis_pend_d          = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q     <= 1'b0;
      mis_pend_q <= 1'b0;
    end else begin
      halt_q     <= halt_d;
      mis_pend_q <= mis_pend_d;
    end
  end
`endif

  if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .count     (fifo_count),
    .head      (head)
  );

  assign bus.imem_req     = req;
  assign bus.imem_addr    = fetch_pc_q;
  assign bus.out_valid    = (fifo_count != '0);
  assign bus.out_pc       = bus.out_valid ? head.pc   : 32'h0;
  assign bus.out_inst     = bus.out_valid ? head.inst : NOP_INST;
  assign bus.out_misalign = bus.out_valid && head.misalign;

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized bench for if_prefetch: imem model with random grant/latency, program-order scoreboard.
// Expected stream: sequential pcs from the last redirect target; a redirect kills everything not yet accepted.
module tb_if_prefetch;
  import cqu_mips_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_if bus();

  if_prefetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAXO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  if_entry_t   exp_q[$];
  logic [31:0] exp_pc = 32'h0;
  bit          halted = 1'b0;
  bit          prev_redir = 1'b0;
  logic [31:0] infl_addr[$];
  int          infl_due[$];
  int          cyc = 0;
  int          gnt_pct = 100, rv_pct = 100, rdy_pct = 100, redir_pct = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic if_entry_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic mis);
    if_entry_t e;
    e.pc = pc; e.inst = inst; e.misalign = mis;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit force_redir, input logic [31:0] fpc);
    logic [31:0] p;
    @(posedge clk);
    #1;
    cyc++;
    bus.imem_gnt  = ($urandom_range(99) < gnt_pct);
    bus.out_ready = ($urandom_range(99) < rdy_pct);
    p = $urandom();
    if (force_redir) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = fpc;
    end else if (redir_pct > 0 && $urandom_range(99) < redir_pct) begin
      if ($urandom_range(9) != 0) p[1:0] = 2'b00;
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = p;
    end else begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = p;
    end
    if (infl_addr.size() > 0 && infl_due[0] <= cyc && $urandom_range(99) < rv_pct) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(infl_addr[0]);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom();
    end
  endtask

  // Scoreboard monitor: grants push expectations, accepted outputs pop and compare.
  initial begin
    if_entry_t   e;
    logic [31:0] rp;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (bus.imem_rvalid)
          assert (infl_addr.size() > 0) else $error("rvalid with no request outstanding");
        if (prev_redir) chk("flush_empty", bus.out_valid, 1'b0);
        if (bus.redirect_valid) chk("redir_no_req", bus.imem_req, 1'b0);
        else if (halted)        chk("halt_no_req", bus.imem_req, 1'b0);

        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_out: got pc %0h expected nothing (cycle %0d)", bus.out_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("out_pc", bus.out_pc, e.pc);
            chk("out_inst", bus.out_inst, e.inst);
            chk("out_misalign", bus.out_misalign, e.misalign);
          end
        end

        if (bus.imem_req && bus.imem_gnt) begin
          chk("imem_addr", bus.imem_addr, exp_pc);
          exp_q.push_back(mk(exp_pc, mem_word(exp_pc), 1'b0));
          exp_pc = exp_pc + 32'd4;
          infl_addr.push_back(bus.imem_addr);
          infl_due.push_back(cyc + 1);
        end

        if (bus.imem_rvalid && infl_addr.size() > 0) begin
          void'(infl_addr.pop_front());
          void'(infl_due.pop_front());
        end

        prev_redir = bus.redirect_valid;
        if (bus.redirect_valid) begin
          exp_q.delete();
          rp = bus.redirect_pc;
`ifdef IF_ALIGN_CHECK_EN
          if (rp[1:0] != 2'b00) begin
            exp_q.push_back(mk(rp, 32'h0, 1'b1));
            halted = 1'b1;
          end else begin
            exp_pc = rp;
            halted = 1'b0;
          end
`else
          exp_pc = {rp[31:2], 2'b00};
          halted = 1'b0;
`endif
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.imem_gnt       = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.out_ready      = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_imem_req", bus.imem_req, 1'b0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_pc", bus.out_pc, 32'h0);
    chk("rst_out_inst", bus.out_inst, 32'h0);
    chk("rst_out_misalign", bus.out_misalign, 1'b0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Full-rate streaming: one instruction per cycle once the pipe fills.
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 32'h0);
      if (i >= 4) begin
        @(negedge clk);
        chk("throughput_valid", bus.out_valid, 1'b1);
      end
    end

    // ID stall: buffer fills to DEPTH and requests stop.
    rdy_pct = 0;
    repeat (10) step(1'b0, 32'h0);
    @(negedge clk);
    chk("stall_buffered", exp_q.size(), DEPTH);
    chk("stall_req", bus.imem_req, 1'b0);
    chk("stall_valid", bus.out_valid, 1'b1);
    rdy_pct = 100;
    repeat (20) step(1'b0, 32'h0);

    // Address wrap across 2^32.
    step(1'b1, 32'hFFFF_FFF8);
    repeat (12) step(1'b0, 32'h0);

    // Redirect with slow responses so reads are in flight.
    rv_pct = 20;
    repeat (4) step(1'b0, 32'h0);
    step(1'b1, 32'h0000_0100);
    rv_pct = 100;
    repeat (12) step(1'b0, 32'h0);

`ifdef IF_ALIGN_CHECK_EN
    step(1'b1, 32'h0000_0102);
    repeat (10) step(1'b0, 32'h0);
    chk("misalign_consumed", exp_q.size(), 0);
    step(1'b1, 32'h0000_0200);
    repeat (10) step(1'b0, 32'h0);
`endif

    // Random traffic with redirects, random grants, latency and backpressure.
    gnt_pct = 70; rv_pct = 50; rdy_pct = 70; redir_pct = 5;
    repeat (3000) step(1'b0, 32'h0);

    // Drain: no new grants, everything expected must come out.
    redir_pct = 0; gnt_pct = 0; rv_pct = 100; rdy_pct = 100;
    k = 0;
    while ((exp_q.size() != 0 || infl_addr.size() != 0) && k < 200) begin
      step(1'b0, 32'h0);
      k++;
    end
    step(1'b0, 32'h0);
    @(negedge clk);
    chk("drain_left", exp_q.size() + infl_addr.size(), 0);
    chk("drain_out_valid", bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
